// File: rtl/imem_loader_if.sv
// imem_loader_if
// Groups the byte-stream handshake and the instruction-memory write port
// used by the loader.
//   byte_valid / byte_data / byte_ready : incoming byte stream
//   we / waddr / wdata                  : instruction memory write port
// Modports:
//   slave  - the loader (consumes bytes, drives the write port)
//   master - the environment (drives bytes, observes the write port)
interface imem_loader_if #(
    parameter int N      = 32,
    parameter int ADDR_W = 6
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [N-1:0]      wdata;

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, we, waddr, wdata
    );

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, we, waddr, wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
// Assembles a byte stream (length byte followed by N/8 bytes per word, MSB
// first) into instruction words and writes them to ascending addresses from 0.
// The processor is held while a load session is active.
// Ports:
//   clk, reset  - rising-edge clock, asynchronous active-high reset
//   start       - begin a session (IDLE only)
//   abort       - synchronous cancel from any state
//   bus         - byte stream in, instruction memory write port out
//   cpu_hold    - high while not IDLE
//   busy        - same as cpu_hold
//   done        - one-cycle pulse on normal completion
//   count       - words written in the current or last session
//
// state   | meaning
// --------+-------------------------------------------------------
// S_IDLE  | waiting for start, processor released
// S_LEN   | waiting for the length byte
// S_DATA  | shifting bytes into the word register
// S_WRITE | one-cycle memory write of the assembled word
// S_DONE  | one-cycle completion pulse
module imem_loader #(
    parameter int N      = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    imem_loader_if.slave      bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count
);
    localparam int BPW   = N / 8;
    localparam int BCW   = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q,  state_d;
    logic [ADDR_W:0]   len_q,    len_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [BCW-1:0]    bcnt_q,   bcnt_d;
    logic [N-1:0]      word_q,   word_d;
    logic [ADDR_W-1:0] waddr_q,  waddr_d;
    logic [N-1:0]      wdata_q,  wdata_d;
    logic [ADDR_W:0]   count_q,  count_d;

    logic              byte_ready_c;
    logic              we_c;
    logic              done_c;
    logic [N-1:0]      shifted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        addr_d       = addr_q;
        bcnt_d       = bcnt_q;
        word_d       = word_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        count_d      = count_q;
        byte_ready_c = 1'b0;
        we_c         = 1'b0;
        done_c       = 1'b0;
        shifted      = (word_q << 8) | N'(bus.byte_data);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LEN;
                    count_d = '0;
                    addr_d  = '0;
                    bcnt_d  = '0;
                end
            end
            S_LEN: begin
                byte_ready_c = 1'b1;
                if (bus.byte_valid) begin
                    // Zero or an oversize length means "fill the whole memory".
                    if (bus.byte_data == 8'd0 || int'(bus.byte_data) > DEPTH)
                        len_d = (ADDR_W+1)'(DEPTH);
                    else
                        len_d = (ADDR_W+1)'(bus.byte_data);
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                byte_ready_c = 1'b1;
                if (bus.byte_valid) begin
                    word_d = shifted;
                    if (bcnt_q == BCW'(BPW - 1)) begin
                        bcnt_d  = '0;
                        // Write port is loaded here so it stays stable outside WRITE.
                        waddr_d = addr_q;
                        wdata_d = shifted;
                        state_d = S_WRITE;
                    end else begin
                        bcnt_d = bcnt_q + BCW'(1);
                    end
                end
            end
            S_WRITE: begin
                we_c    = 1'b1;
                count_d = count_q + (ADDR_W+1)'(1);
                if ({1'b0, addr_q} == len_q - (ADDR_W+1)'(1)) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_DATA;
                end
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything: partial word dropped, count frozen.
        if (abort) begin
            state_d = S_IDLE;
            we_c    = 1'b0;
            done_c  = 1'b0;
            count_d = count_q;
            addr_d  = addr_q;
            bcnt_d  = '0;
            word_d  = '0;
            waddr_d = waddr_q;
            wdata_d = wdata_q;
        end
    end

    assign bus.byte_ready = byte_ready_c;
    assign bus.we         = we_c;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
    assign busy           = (state_q != S_IDLE);
    assign cpu_hold       = busy;
    assign done           = done_c;
    assign count          = count_q;
endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    localparam int N      = 32;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam int BPW    = N / 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            abort;
    logic            cpu_hold;
    logic            busy;
    logic            done;
    logic [ADDR_W:0] count;

    imem_loader_if #(.N(N), .ADDR_W(ADDR_W)) bus ();

    imem_loader #(.N(N), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .bus      (bus.slave),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [N-1:0]      d;
    } wr_t;

    wr_t      got_q[$];
    int       done_cnt      = 0;
    int       done_cyc      = -1;
    int       last_we_cyc   = -1;
    int       bad_ready_cnt = 0;
    logic [N-1:0] fixed_q[$];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Observer of the write port and done pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.we) begin
                got_q.push_back('{a: bus.waddr, d: bus.wdata});
                last_we_cyc = cyc;
                if (bus.byte_ready) bad_ready_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Reference: number of words a length byte requests.
    function automatic int model_len(input logic [7:0] b);
        if (b == 8'd0 || int'(b) > DEPTH) return DEPTH;
        return int'(b);
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int w;
        int g;
        g = 0;
        while (gap && g < 3 && $urandom_range(0, 1) == 1) begin
            bus.byte_valid = 1'b0;
            @(negedge clk);
            g++;
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        w = 0;
        while (!bus.byte_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!bus.byte_ready) begin
            checks++;
            failures++;
            $display("FAIL byte_accept_timeout: byte_ready got 0 expected 1");
        end
        @(negedge clk);
    endtask

    task automatic run_load(input string tag, input logic [7:0] len_byte, input bit gap,
                            input int exp_count, input bit mid_start);
        logic [N-1:0] words[$];
        int L;
        int t0;
        int w;
        L = model_len(len_byte);
        words = {};
        for (int i = 0; i < L; i++)
            words.push_back((i < fixed_q.size()) ? fixed_q[i] : N'($urandom()));
        got_q.delete();
        done_cnt      = 0;
        done_cyc      = -1;
        last_we_cyc   = -1;
        bad_ready_cnt = 0;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        chk({tag, " busy_after_start"}, 64'(busy), 64'd1);
        chk({tag, " ready_after_start"}, 64'(bus.byte_ready), 64'd1);

        send_byte(len_byte, gap);
        for (int i = 0; i < L; i++) begin
            for (int k = 0; k < BPW; k++) begin
                if (mid_start && i == 0 && k == 2) start = 1'b1;
                send_byte(words[i][N-1-8*k -: 8], gap);
                start = 1'b0;
            end
        end
        bus.byte_valid = 1'b0;

        w = 0;
        while (busy && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " idle_at_end"}, 64'(busy), 64'd0);
        chk({tag, " count"}, 64'(count), 64'(exp_count));
        chk({tag, " n_writes"}, 64'(got_q.size()), 64'(exp_count));
        chk({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, " done_after_last_we"}, 64'(done_cyc), 64'(last_we_cyc + 1));
        chk({tag, " ready_low_in_write"}, 64'(bad_ready_cnt), 64'd0);
        if (!gap)
            chk({tag, " session_cycles"}, 64'(done_cyc - t0), 64'(L * (BPW + 1) + 1));
        for (int i = 0; i < got_q.size() && i < L; i++) begin
            chk({tag, " waddr"}, 64'(got_q[i].a), 64'(i));
            chk({tag, " wdata"}, 64'(got_q[i].d), 64'(words[i]));
        end
    endtask

    typedef struct {
        logic [7:0] len_byte;
        bit         gap;
        bit         mid_start;
        int         exp_count;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h02, 1'b0, 1'b0, 2};
        vecs[1] = '{8'h00, 1'b0, 1'b0, 64};
        vecs[2] = '{8'hC8, 1'b0, 1'b0, 64};
        vecs[3] = '{8'h02, 1'b1, 1'b0, 2};
        vecs[4] = '{8'h05, 1'b1, 1'b0, 5};
        vecs[5] = '{8'h40, 1'b0, 1'b0, 64};
        vecs[6] = '{8'h41, 1'b1, 1'b0, 64};
        vecs[7] = '{8'h3F, 1'b0, 1'b0, 63};
        vecs[8] = '{8'h01, 1'b0, 1'b1, 1};
        vecs[9] = '{8'h03, 1'b1, 1'b1, 3};

        reset          = 1'b1;
        start          = 1'b0;
        abort          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        #12;
        chk("rst byte_ready", 64'(bus.byte_ready), 64'd0);
        chk("rst we", 64'(bus.we), 64'd0);
        chk("rst waddr", 64'(bus.waddr), 64'd0);
        chk("rst wdata", 64'(bus.wdata), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst cpu_hold", 64'(cpu_hold), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst count", 64'(count), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reference example stream.
        fixed_q = {32'hF8000000, 32'hF8008001};
        run_load("example", 8'h02, 1'b0, 2, 1'b0);
        fixed_q.delete();

        for (int v = 0; v < 10; v++)
            run_load($sformatf("vec%0d", v), vecs[v].len_byte, vecs[v].gap,
                     vecs[v].exp_count, vecs[v].mid_start);

        // Abort after 3 bytes of the second word.
        got_q.delete();
        done_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h05, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'h78, 1'b0);
        send_byte(8'h9A, 1'b0);
        send_byte(8'hBC, 1'b0);
        send_byte(8'hDE, 1'b0);
        bus.byte_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        chk("abort n_writes", 64'(got_q.size()), 64'd1);
        chk("abort done", 64'(done_cnt), 64'd0);
        chk("abort count", 64'(count), 64'd1);
        if (got_q.size() > 0) begin
            chk("abort waddr0", 64'(got_q[0].a), 64'd0);
            chk("abort wdata0", 64'(got_q[0].d), 64'h12345678);
        end
        run_load("after_abort", 8'h04, 1'b0, 4, 1'b0);

        // start together with abort in IDLE.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort busy", 64'(busy), 64'd0);
        chk("start_abort ready", 64'(bus.byte_ready), 64'd0);
        @(negedge clk);
        chk("start_abort busy2", 64'(busy), 64'd0);

        // Reset asserted mid-DATA with 2 bytes of a word received.
        got_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h04, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        chk("pre_reset ready", 64'(bus.byte_ready), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst we", 64'(bus.we), 64'd0);
        chk("async_rst busy", 64'(busy), 64'd0);
        chk("async_rst ready", 64'(bus.byte_ready), 64'd0);
        chk("async_rst cpu_hold", 64'(cpu_hold), 64'd0);
        bus.byte_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst busy", 64'(busy), 64'd0);
        chk("post_rst count", 64'(count), 64'd0);
        chk("post_rst n_writes", 64'(got_q.size()), 64'd0);
        run_load("after_reset", 8'h03, 1'b1, 3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
